// File: rtl/pulse_seq_pkg.sv
// pulse_seq_pkg: shared state encoding and helpers for the pulse sequence detector.
// Used by pulse_seq_chan and pulse_seq_fsm. Optional feature macro: PULSE_SEQ_TIMEOUT_EN.
package pulse_seq_pkg;

    localparam int STATE_W = 4;

    // One-hot channel states; any other bit pattern is treated as illegal.
    typedef enum logic [STATE_W-1:0] {
        IDLE  = 4'b1000,
        START = 4'b0100,
        STOP  = 4'b0010,
        CLEAR = 4'b0001
    } state_t;

    // Level of the input line that advances the given state.
    // Idle and Stop wait for a rise (1), Start and Clear wait for a fall (0).
    function automatic logic target_level(input state_t s);
        logic lvl;
        case (s)
            START, CLEAR: lvl = 1'b0;
            default:      lvl = 1'b1;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/pulse_seq_chan.sv
// pulse_seq_chan: one channel of the rise/fall/rise/fall detector with hold
// qualification, illegal-state recovery and an optional stuck-phase timeout
// (built only when PULSE_SEQ_TIMEOUT_EN is defined).
module pulse_seq_chan
    import pulse_seq_pkg::*;
#(
    parameter int HOLD_W = 4,
    parameter int TO_W   = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_a,
    input  logic [HOLD_W-1:0] i_hold_cfg,
    input  logic [TO_W-1:0]   i_timeout_cfg,
    input  logic              i_clr,
    output logic              o_k2,
    output logic              o_k1,
    output logic              o_busy,
    output logic              o_err
);

    state_t              r_state;
    logic [HOLD_W-1:0]   r_hold;
    logic                r_k2;
    logic                r_k1;
    logic                r_err;

    state_t              w_state_next;
    logic [HOLD_W-1:0]   w_hold_next;
    logic [HOLD_W-1:0]   w_hold_inc;
    logic                w_k2_next;
    logic                w_k1_next;
    logic                w_err_next;
    logic                w_match;
    logic                w_qual;
    logic                w_timeout;

    // The hold counter holds the number of earlier consecutive samples at the
    // target level, so the current sample qualifies once it reaches hold_cfg.
    assign w_match    = (i_a == target_level(r_state));
    assign w_qual     = w_match && (r_hold >= i_hold_cfg);
    assign w_hold_inc = (r_hold == '1) ? r_hold : r_hold + HOLD_W'(1);

`ifdef PULSE_SEQ_TIMEOUT_EN
    logic [TO_W-1:0] r_to;
    logic [TO_W-1:0] w_to_inc;

    // Timeout fires on the edge that would bring the dwell count up to timeout_cfg;
    // >= keeps a lowered timeout_cfg effective against a count already past it.
    assign w_to_inc  = (r_to == '1) ? r_to : r_to + TO_W'(1);
    assign w_timeout = (i_timeout_cfg != '0) && (r_state != IDLE) && (w_to_inc >= i_timeout_cfg);

    // Dwell counter for the current non-Idle state, cleared on any state change.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to <= '0;
        end else if (i_clr || (w_state_next != r_state) || (r_state == IDLE)) begin
            r_to <= '0;
        end else begin
            r_to <= w_to_inc;
        end
    end
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = ^i_timeout_cfg;
    assign w_timeout            = 1'b0;
`endif

    // Next state and pulses; priority is clr, illegal recovery, qualified transition, timeout.
    always_comb begin
        w_state_next = r_state;
        w_k2_next    = 1'b0;
        w_k1_next    = 1'b0;
        w_err_next   = 1'b0;
        if (i_clr) begin
            w_state_next = IDLE;
        end else if (!$onehot(r_state)) begin
            w_state_next = IDLE;
            w_err_next   = 1'b1;
        end else if (w_qual) begin
            case (r_state)
                IDLE:    w_state_next = START;
                START:   w_state_next = STOP;
                STOP: begin
                    w_state_next = CLEAR;
                    w_k2_next    = 1'b1;
                end
                CLEAR: begin
                    w_state_next = IDLE;
                    w_k1_next    = 1'b1;
                end
                default: w_state_next = IDLE;
            endcase
        end else if (w_timeout) begin
            w_state_next = IDLE;
            w_err_next   = 1'b1;
        end
        w_hold_next = w_hold_inc;
        if (i_clr || (w_state_next != r_state) || !w_match) begin
            w_hold_next = '0;
        end
    end

    // State, hold count and output pulse registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_hold  <= '0;
            r_k2    <= 1'b0;
            r_k1    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_hold  <= w_hold_next;
            r_k2    <= w_k2_next;
            r_k1    <= w_k1_next;
            r_err   <= w_err_next;
        end
    end

    assign o_k2   = r_k2;
    assign o_k1   = r_k1;
    assign o_err  = r_err;
    assign o_busy = (r_state != IDLE);

endmodule

// File: rtl/pulse_seq_fsm.sv
// pulse_seq_fsm: CH independent pulse sequence detector channels sharing
// hold/timeout configuration and a synchronous abort. Timeout logic is built
// only when PULSE_SEQ_TIMEOUT_EN is defined.
module pulse_seq_fsm
    import pulse_seq_pkg::*;
#(
    parameter int CH     = 4,
    parameter int HOLD_W = 4,
    parameter int TO_W   = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [CH-1:0]     i_a,
    input  logic [HOLD_W-1:0] i_hold_cfg,
    input  logic [TO_W-1:0]   i_timeout_cfg,
    input  logic              i_clr,
    output logic [CH-1:0]     o_k2,
    output logic [CH-1:0]     o_k1,
    output logic [CH-1:0]     o_busy,
    output logic [CH-1:0]     o_err
);

    // One detector per monitored line.
    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_chan
            pulse_seq_chan #(
                .HOLD_W (HOLD_W),
                .TO_W   (TO_W)
            ) u_chan (
                .i_clk         (i_clk),
                .i_rst_n       (i_rst_n),
                .i_a           (i_a[gi]),
                .i_hold_cfg    (i_hold_cfg),
                .i_timeout_cfg (i_timeout_cfg),
                .i_clr         (i_clr),
                .o_k2          (o_k2[gi]),
                .o_k1          (o_k1[gi]),
                .o_busy        (o_busy[gi]),
                .o_err         (o_err[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_pulse_seq_fsm.sv
// tb_pulse_seq_fsm: directed, scoreboard-checked bench for pulse_seq_fsm.
// Expectations for the timeout scenario follow PULSE_SEQ_TIMEOUT_EN.
module tb_pulse_seq_fsm;

    localparam int CH     = 4;
    localparam int HOLD_W = 4;
    localparam int TO_W   = 8;
`ifdef PULSE_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic [CH-1:0]     i_a;
    logic [HOLD_W-1:0] i_hold_cfg;
    logic [TO_W-1:0]   i_timeout_cfg;
    logic              i_clr;
    logic [CH-1:0]     o_k2;
    logic [CH-1:0]     o_k1;
    logic [CH-1:0]     o_busy;
    logic [CH-1:0]     o_err;

    typedef struct packed {
        logic [CH-1:0] k2;
        logic [CH-1:0] k1;
        logic [CH-1:0] busy;
        logic [CH-1:0] err;
    } exp_t;

    exp_t  exp_q[$];
    int    n_checks = 0;
    int    n_fails  = 0;
    string cur_tag  = "init";

    pulse_seq_fsm #(
        .CH     (CH),
        .HOLD_W (HOLD_W),
        .TO_W   (TO_W)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_a           (i_a),
        .i_hold_cfg    (i_hold_cfg),
        .i_timeout_cfg (i_timeout_cfg),
        .i_clr         (i_clr),
        .o_k2          (o_k2),
        .o_k1          (o_k1),
        .o_busy        (o_busy),
        .o_err         (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string field, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s.%s observed=%b expected=%b", cur_tag, field, obs, exp);
        end
    endtask

    // Pop the oldest expectation and compare it with the current outputs.
    task automatic compare_out();
        exp_t e;
        n_checks++;
        assert (exp_q.size() > 0) else begin
            n_fails++;
            $error("FAIL %s.scoreboard observed=empty expected=entry", cur_tag);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("k2",   o_k2,   e.k2);
            chk("k1",   o_k1,   e.k1);
            chk("busy", o_busy, e.busy);
            chk("err",  o_err,  e.err);
        end
    endtask

    // Drive one cycle of stimulus, record what must appear after the edge, then check.
    task automatic step(input string tag, input logic [CH-1:0] a, input logic c,
                        input logic [CH-1:0] k2, input logic [CH-1:0] k1,
                        input logic [CH-1:0] busy, input logic [CH-1:0] err);
        cur_tag = tag;
        i_a     = a;
        i_clr   = c;
        exp_q.push_back(exp_t'{k2, k1, busy, err});
        @(posedge clk);
        #1;
        compare_out();
        $display("step %-10s a=%b clr=%b -> k2=%b k1=%b busy=%b err=%b",
                 tag, a, c, o_k2, o_k1, o_busy, o_err);
    endtask

    initial begin
        logic [CH-1:0] a6, k26, k16, b6;
        rst_n         = 1'b0;
        i_a           = '0;
        i_hold_cfg    = '0;
        i_timeout_cfg = '0;
        i_clr         = 1'b0;

        // Reset state
        #12;
        cur_tag = "reset";
        exp_q.push_back(exp_t'{4'b0000, 4'b0000, 4'b0000, 4'b0000});
        compare_out();
        #1 rst_n = 1'b1;

        // Basic 1,0,1,0 on channel 0 with immediate qualification
        step("t1_r1",   4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        step("t1_f1",   4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        step("t1_r2",   4'b0001, 1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
        step("t1_f2",   4'b0000, 1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        step("t1_idle", 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Glitch rejection on channel 1 with hold_cfg=2, then a 3-cycle rise
        i_hold_cfg = 4'd2;
        step("t2_g1",   4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("t2_g2",   4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("t2_gl",   4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("t2_h1",   4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("t2_h2",   4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("t2_h3",   4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
        i_hold_cfg = 4'd0;
        step("t2_f1",   4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
        step("t2_r2",   4'b0010, 1'b0, 4'b0010, 4'b0000, 4'b0010, 4'b0000);
        step("t2_f2",   4'b0000, 1'b0, 4'b0000, 4'b0010, 4'b0000, 4'b0000);

        // Channel 2, timeout_cfg=5: a fall on the 5th Start edge beats the timeout,
        // then the channel stalls in Stop until the timeout (when built) aborts it
        i_timeout_cfg = 8'd5;
        step("t3_s0",   4'b0100, 1'b0, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
        for (int i = 1; i <= 4; i++)
            step($sformatf("t3_s%0d", i), 4'b0100, 1'b0, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
        step("t3_s5",   4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
        for (int i = 1; i <= 4; i++)
            step($sformatf("t3_w%0d", i), 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
        step("t3_w5",   4'b0000, 1'b0, 4'b0000, 4'b0000,
             TO_EN ? 4'b0000 : 4'b0100, TO_EN ? 4'b0100 : 4'b0000);
        step("t3_w6",   4'b0000, 1'b0, 4'b0000, 4'b0000,
             TO_EN ? 4'b0000 : 4'b0100, 4'b0000);
        step("t3_clr",  4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        i_timeout_cfg = 8'd0;

        // clr on the edge where the qualifying fall arrives in Clear (channel 3)
        step("t4_r1",   4'b1000, 1'b0, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
        step("t4_f1",   4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
        step("t4_r2",   4'b1000, 1'b0, 4'b1000, 4'b0000, 4'b1000, 4'b0000);
        step("t4_clr",  4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step("t4_idle", 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Asynchronous reset between edges while channel 0 sits in Stop
        step("t5_r1",   4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        step("t5_f1",   4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        #2 rst_n = 1'b0;
        #1;
        cur_tag = "t5_async_rst";
        exp_q.push_back(exp_t'{4'b0000, 4'b0000, 4'b0000, 4'b0000});
        compare_out();
        $display("step %-10s async reset -> k2=%b k1=%b busy=%b err=%b",
                 cur_tag, o_k2, o_k1, o_busy, o_err);
        #1 rst_n = 1'b1;
        step("t5_r1b",  4'b0001, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        step("t5_f1b",  4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        step("t5_r2b",  4'b0001, 1'b0, 4'b0001, 4'b0000, 4'b0001, 4'b0000);
        step("t5_f2b",  4'b0000, 1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0000);

        // All channels, 1,0,1,0 each, channel c starting c cycles late
        for (int t = 0; t < 8; t++) begin
            for (int c = 0; c < CH; c++) begin
                int s;
                s      = t - c;
                a6[c]  = (s == 0) || (s == 2);
                b6[c]  = (s >= 0) && (s <= 2);
                k26[c] = (s == 2);
                k16[c] = (s == 3);
            end
            step($sformatf("t6_%0d", t), a6, 1'b0, k26, k16, b6, 4'b0000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Run-time bound
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
